// File: rtl/tc_pkg.sv
// rtl/tc_pkg.sv - shared types and constants for the memory-mapped down-counting timer
package tc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    CNT  = 2'b10,
    INT  = 2'b11
  } tc_state_e;

  localparam logic [1:0] CTRL_OFF   = 2'b00;
  localparam logic [1:0] PRESET_OFF = 2'b01;
  localparam logic [1:0] COUNT_OFF  = 2'b10;

  localparam int EN_BIT   = 0;
  localparam int MODE_LSB = 1;
  localparam int MODE_MSB = 2;
  localparam int IM_BIT   = 3;
  localparam int CTRL_W   = 4;

  localparam logic [1:0] MODE_ONESHOT = 2'b00;
  localparam logic [1:0] MODE_RELOAD  = 2'b01;

endpackage

// File: rtl/timer_counter.sv
// rtl/timer_counter.sv - memory-mapped down-counting timer with one-shot / auto-reload modes and IRQ
module timer_counter
  import tc_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_7F00,
  parameter int          WIDTH     = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      Addr,
  input  logic             WE,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Dout,
  output logic             IRQ
);

  tc_state_e          state_q, state_d;
  logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
  logic [WIDTH-1:0]   preset_q, preset_d;
  logic [WIDTH-1:0]   count_q, count_d;
  logic               irq_flag_q, irq_flag_d;
  logic               irq_q;

  logic wr_ctrl, wr_preset, en, reload, cnt_done;
  logic unused_addr;

  // Only Addr[3:2] selects a register; the instance base is decoded by the bridge.
  assign unused_addr = ^{Addr[31:4], Addr[1:0], BASE_ADDR};

  assign wr_ctrl   = WE && (Addr[3:2] == CTRL_OFF);
  assign wr_preset = WE && (Addr[3:2] == PRESET_OFF);
  assign en        = ctrl_q[EN_BIT];
  assign reload    = (ctrl_q[MODE_MSB:MODE_LSB] == MODE_RELOAD);
  assign cnt_done  = (count_q <= WIDTH'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (en) state_d = LOAD;
      LOAD: state_d = CNT;
      CNT: begin
        if (!en) begin
          state_d = IDLE;
        end else if (cnt_done) begin
          state_d = INT;
        end
      end
      INT: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;
    unique case (state_q)
      LOAD: count_d = preset_q;
      CNT: begin
        if (en) begin
          if (cnt_done) begin
            count_d    = '0;
            irq_flag_d = 1'b1;
          end else begin
            count_d = count_q - WIDTH'(1);
          end
        end
      end
      INT: begin
        if (reload) begin
          irq_flag_d = 1'b0;
        end else begin
          ctrl_d[EN_BIT] = 1'b0;
        end
      end
      default: ;
    endcase
    // Software writes land after the FSM update so they win in a same-cycle collision.
    if (wr_ctrl) begin
      ctrl_d     = Din[CTRL_W-1:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = Din;
      irq_flag_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl_q     <= '0;
      preset_q   <= '0;
      count_q    <= '0;
      irq_flag_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
      irq_q      <= irq_flag_q & ctrl_q[IM_BIT];
    end
  end

  always_comb begin
    Dout = '0;
    unique case (Addr[3:2])
      CTRL_OFF:   Dout = {{(WIDTH-CTRL_W){1'b0}}, ctrl_q};
      PRESET_OFF: Dout = preset_q;
      COUNT_OFF:  Dout = count_q;
      default:    Dout = '0;
    endcase
  end

  assign IRQ = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb/tb_timer_counter.sv - directed self-checking bench for timer_counter
module tb_timer_counter;

  localparam logic [31:0] A_CTRL   = 32'h0000_7F00;
  localparam logic [31:0] A_PRESET = 32'h0000_7F04;
  localparam logic [31:0] A_COUNT  = 32'h0000_7F08;
  localparam logic [31:0] A_NONE   = 32'h0000_7F0C;

  logic        clk   = 1'b0;
  logic        reset = 1'b0;
  logic        WE    = 1'b0;
  logic [31:0] Addr  = '0;
  logic [31:0] Din   = '0;
  logic [31:0] Dout;
  logic        IRQ;

  int total = 0;
  int bad   = 0;

  timer_counter #(.BASE_ADDR(32'h0000_7F00), .WIDTH(32)) dut (
    .clk   (clk),
    .reset (reset),
    .Addr  (Addr),
    .WE    (WE),
    .Din   (Din),
    .Dout  (Dout),
    .IRQ   (IRQ)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic check_reg(input string tag, input logic [31:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    check(tag, Dout, exp);
  endtask

  task automatic check_irq(input string tag, input logic exp);
    check(tag, {31'b0, IRQ}, {31'b0, exp});
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    Addr = a;
    Din  = d;
    WE   = 1'b1;
    @(negedge clk);
    WE   = 1'b0;
  endtask

  initial begin
    tick(3);
    reset = 1'b1;
    tick(1);
    check_reg("rst_ctrl", A_CTRL, 32'h0);
    check_reg("rst_preset", A_PRESET, 32'h0);
    check_reg("rst_count", A_COUNT, 32'h0);
    check_irq("rst_irq", 1'b0);

    // one-shot, IM=1
    wr(A_PRESET, 32'd5);
    wr(A_CTRL, 32'h9);
    check_reg("os_idle_count", A_COUNT, 32'd0);
    tick(1);
    check_reg("os_load_count", A_COUNT, 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check_reg($sformatf("os_count_%0d", i), A_COUNT, 32'(5 - i));
      check_irq($sformatf("os_irq_low_%0d", i), 1'b0);
    end
    tick(1);
    check_irq("os_irq_set", 1'b1);
    check_reg("os_en_cleared", A_CTRL, 32'h8);
    tick(1);
    check_irq("os_irq_held", 1'b1);
    check_reg("os_count_zero", A_COUNT, 32'd0);
    wr(A_CTRL, 32'h0);
    tick(1);
    check_irq("os_irq_cleared", 1'b0);

    // auto-reload, period PRESET+3 = 6
    wr(A_PRESET, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 24; k++) begin
      tick(1);
      check_irq($sformatf("ar_irq_k%0d", k), (k % 6) == 0);
    end
    wr(A_CTRL, 32'h0);
    tick(3);
    check_irq("ar_stopped", 1'b0);

    // masked one-shot
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 6; k++) begin
      tick(1);
      check_irq($sformatf("mask_irq_k%0d", k), 1'b0);
    end
    check_reg("mask_en_cleared", A_CTRL, 32'h0);
    check_reg("mask_count", A_COUNT, 32'd0);

    // disable at COUNT=4, then re-enable restarts from PRESET
    wr(A_PRESET, 32'd10);
    wr(A_CTRL, 32'h1);
    tick(6);
    check_reg("dis_count6", A_COUNT, 32'd6);
    wr(A_CTRL, 32'h0);
    check_reg("dis_count4", A_COUNT, 32'd4);
    tick(3);
    check_reg("dis_frozen", A_COUNT, 32'd4);
    wr(A_CTRL, 32'h1);
    tick(1);
    check_reg("reen_load", A_COUNT, 32'd4);
    tick(1);
    check_reg("reen_reload", A_COUNT, 32'd10);
    tick(1);
    check_reg("reen_dec", A_COUNT, 32'd9);
    wr(A_CTRL, 32'h0);
    tick(2);
    check_reg("reen_frozen", A_COUNT, 32'd7);

    // writes to COUNT and the unused slot are ignored
    wr(A_COUNT, 32'h1234);
    check_reg("wr08_count", A_COUNT, 32'd7);
    wr(A_NONE, 32'hFFFF_FFFF);
    check_reg("wr0c_ctrl", A_CTRL, 32'h0);
    check_reg("wr0c_preset", A_PRESET, 32'd10);
    check_reg("wr0c_count", A_COUNT, 32'd7);
    check_reg("rd0c_zero", A_NONE, 32'h0);
    wr(A_CTRL, 32'hFFFF_FFFF);
    check_reg("ctrl_mask", A_CTRL, 32'h0000_000F);
    wr(A_CTRL, 32'h0);
    tick(2);

    // PRESET=0 behaves as 1
    wr(A_PRESET, 32'd0);
    wr(A_CTRL, 32'h1);
    tick(1);
    check_reg("p0_load", A_COUNT, 32'd10);
    tick(1);
    check_reg("p0_cnt", A_COUNT, 32'd0);
    check_reg("p0_cnt_en", A_CTRL, 32'h1);
    tick(1);
    check_reg("p0_int_count", A_COUNT, 32'd0);
    check_reg("p0_int_en", A_CTRL, 32'h1);
    tick(1);
    check_reg("p0_idle_en", A_CTRL, 32'h0);

    // CTRL write in the same cycle as one-shot INT
    wr(A_PRESET, 32'd2);
    wr(A_CTRL, 32'h9);
    tick(3);
    check_reg("col_pre_count", A_COUNT, 32'd1);
    wr(A_CTRL, 32'h9);
    check_reg("col_en_kept", A_CTRL, 32'h9);
    tick(1);
    check_irq("col_flag_cleared", 1'b0);
    check_reg("col_idle_count", A_COUNT, 32'd0);
    tick(1);
    check_reg("col_reload", A_COUNT, 32'd2);

    // reset mid-count
    wr(A_PRESET, 32'd20);
    wr(A_CTRL, 32'h9);
    tick(15);
    check_reg("rm_count7", A_COUNT, 32'd7);
    reset = 1'b0;
    #1;
    check_irq("rm_irq", 1'b0);
    check_reg("rm_count", A_COUNT, 32'd0);
    check_reg("rm_ctrl", A_CTRL, 32'h0);
    check_reg("rm_preset", A_PRESET, 32'h0);
    tick(1);
    reset = 1'b1;
    tick(3);
    check_reg("rm_after_count", A_COUNT, 32'd0);
    check_irq("rm_after_irq", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
